// File: rtl/sine_phase_gen_pkg.sv
// rtl/sine_phase_gen_pkg.sv - shared types and helpers for the sine phase generator
package sine_phase_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pg_state_t;

  function automatic int phase_w(input int aw, input int fw);
    return aw + fw;
  endfunction

endpackage

// File: rtl/sine_phase_gen_phase_acc.sv
// rtl/sine_phase_gen_phase_acc.sv - PW-bit phase accumulator with carry and registered wrap pulse
module phase_acc #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FRAC_WIDTH    = 8,
  parameter int PW            = ADDRESS_WIDTH + FRAC_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [PW-1:0]            i_incr,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic                     o_carry,
  output logic                     o_wrap
);

  logic [PW-1:0] r_phase;
  logic          r_wrap;
  logic [PW:0]   w_sum;

  assign w_sum   = {1'b0, r_phase} + {1'b0, i_incr};
  // Carry of the update happening at the coming edge; the FSM keys config loads on it.
  assign o_carry = i_en & w_sum[PW];
  assign o_addr  = r_phase[PW-1:FRAC_WIDTH];
  assign o_wrap  = r_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= o_carry;
      if (i_en) r_phase <= w_sum[PW-1:0];
    end
  end

endmodule

// File: rtl/sine_phase_gen.sv
// rtl/sine_phase_gen.sv - phase-accumulator ROM address generator with glitch-free config loads
// Optional frequency sweep on wraps: SINE_PHASE_GEN_SWEEP_EN.
module sine_phase_gen
  import sine_phase_gen_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          DATA_WIDTH    = 8,
  parameter int          FRAC_WIDTH    = 8,
  parameter int unsigned DEFAULT_INCR  = 1 << FRAC_WIDTH,
  parameter int unsigned DEFAULT_STEP  = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [phase_w(ADDRESS_WIDTH, FRAC_WIDTH)-1:0] cfg_incr,
  input  logic [DATA_WIDTH-1:0]                         cfg_step,
  output logic [ADDRESS_WIDTH-1:0]                      addr,
  output logic [DATA_WIDTH-1:0]                         step,
  output logic                                          wrap
`ifdef SINE_PHASE_GEN_SWEEP_EN
  ,
  input  logic [phase_w(ADDRESS_WIDTH, FRAC_WIDTH)-1:0] sweep_delta,
  input  logic [phase_w(ADDRESS_WIDTH, FRAC_WIDTH)-1:0] sweep_max
`endif
);

  localparam int PW = phase_w(ADDRESS_WIDTH, FRAC_WIDTH);

  pg_state_t             r_state, w_state_next;
  logic [PW-1:0]         r_incr, r_sh_incr;
  logic [DATA_WIDTH-1:0] r_step, r_sh_step;
  logic                  w_carry, w_capture, w_load;

  phase_acc #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .FRAC_WIDTH   (FRAC_WIDTH),
    .PW           (PW)
  ) u_acc (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_incr (r_incr),
    .o_addr (addr),
    .o_carry(w_carry),
    .o_wrap (wrap)
  );

  assign cfg_ready = (r_state == IDLE);
  assign step      = r_step;

  // A pending config lands on the carrying update (old incr used) or at once when stalled.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_capture    = 1'b1;
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (!en || w_carry) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef SINE_PHASE_GEN_SWEEP_EN
  logic [PW-1:0] r_base_incr;
  logic [PW:0]   w_sweep_sum;

  assign w_sweep_sum = {1'b0, r_incr} + {1'b0, sweep_delta};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base_incr <= PW'(DEFAULT_INCR);
    end else if (w_load) begin
      r_base_incr <= r_sh_incr;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_incr    <= PW'(DEFAULT_INCR);
      r_step    <= DATA_WIDTH'(DEFAULT_STEP);
      r_sh_incr <= '0;
      r_sh_step <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_sh_incr <= cfg_incr;
        r_sh_step <= cfg_step;
      end
      if (w_load) begin
        r_incr <= r_sh_incr;
        r_step <= r_sh_step;
      end
`ifdef SINE_PHASE_GEN_SWEEP_EN
      else if (r_state == IDLE && w_carry && sweep_delta != '0) begin
        if (w_sweep_sum > {1'b0, sweep_max}) r_incr <= r_base_incr;
        else                                 r_incr <= w_sweep_sum[PW-1:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_sine_phase_gen.sv
// tb/tb_sine_phase_gen.sv - randomized scoreboard bench for sine_phase_gen against an arithmetic model
module tb_sine_phase_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_incr;
  logic [7:0]  cfg_step;
  logic [7:0]  addr;
  logic [7:0]  step;
  logic        wrap;
`ifdef SINE_PHASE_GEN_SWEEP_EN
  logic [15:0] sweep_delta;
  logic [15:0] sweep_max;
`endif

  sine_phase_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_incr   (cfg_incr),
    .cfg_step   (cfg_step),
    .addr       (addr),
    .step       (step),
    .wrap       (wrap)
`ifdef SINE_PHASE_GEN_SWEEP_EN
    ,
    .sweep_delta(sweep_delta),
    .sweep_max  (sweep_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int step;
    bit wrap;
    bit ready;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Stimulus intent, applied at each falling edge by tick().
  bit          s_rst, s_en, s_valid;
  logic [15:0] s_incr;
  logic [7:0]  s_step;

  // Reference model: phase as a plain integer modulo 65536.
  longint m_phase, m_incr, m_sh_incr;
  int     m_step, m_sh_step;
  bit     m_pend, m_wrap, m_acc;

  task automatic model_step();
    bit     was_pend;
    bit     carry;
    longint sum;
    m_acc = 1'b0;
    if (s_rst) begin
      m_phase = 0;
      m_incr  = 256;
      m_step  = 64;
      m_pend  = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      was_pend = m_pend;
      carry    = 1'b0;
      if (s_en) begin
        sum     = m_phase + m_incr;
        carry   = (sum >= 65536);
        m_phase = sum % 65536;
      end
      m_wrap = carry;
      if (was_pend && (!s_en || carry)) begin
        m_incr = m_sh_incr;
        m_step = m_sh_step;
        m_pend = 1'b0;
      end else if (!was_pend && s_valid) begin
        m_sh_incr = s_incr;
        m_sh_step = s_step;
        m_pend    = 1'b1;
        m_acc     = 1'b1;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst       = s_rst;
    en        = s_en;
    cfg_valid = s_valid;
    cfg_incr  = s_incr;
    cfg_step  = s_step;
    model_step();
    e.addr  = int'(m_phase >> 8);
    e.step  = m_step;
    e.wrap  = m_wrap;
    e.ready = !m_pend;
    q.push_back(e);
  endtask

  task automatic send_cfg(input logic [15:0] inc, input logic [7:0] st);
    int n;
    s_valid = 1'b1;
    s_incr  = inc;
    s_step  = st;
    n       = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 1000);
    s_valid = 1'b0;
    if (!m_acc) begin
      errors++;
      $display("FAIL cfg_accept: not accepted after %0d cycles, required acceptance", n);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: one expectation per clock, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (addr !== 8'(e.addr) || step !== 8'(e.step) || wrap !== e.wrap || cfg_ready !== e.ready) begin
          errors++;
          $display("FAIL outputs cyc %0d: got addr=%0d step=%0d wrap=%b ready=%b, required addr=%0d step=%0d wrap=%b ready=%b",
                   cyc, addr, step, wrap, cfg_ready, e.addr, e.step, e.wrap, e.ready);
        end
      end
    end
  end

  initial begin
    int r;
`ifdef SINE_PHASE_GEN_SWEEP_EN
    sweep_delta = '0;
    sweep_max   = '0;
`endif
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_incr = '0; cfg_step = '0;
    s_rst = 1'b1; s_en = 1'b0; s_valid = 1'b0; s_incr = '0; s_step = '0;
    m_sh_incr = 0; m_sh_step = 0;

    // Reset then idle cycles.
    run(2);
    s_rst = 1'b0;
    run(3);

    // Full address sweep at default increment, including the 255->0 wrap.
    s_en = 1'b1;
    run(260);

    // Stalled config load, then half-rate stepping.
    s_en = 1'b0;
    send_cfg(16'h0080, 8'd32);
    run(2);
    s_en = 1'b1;
    run(20);

    // Load while running: deferred until the wrap.
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    s_en  = 1'b1;
    while ((m_phase >> 8) != 10) tick();
    send_cfg(16'h0200, 8'd16);
    run(260);

    // Reset while pending discards the config.
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    s_en  = 1'b1;
    run(4);
    send_cfg(16'h0300, 8'd5);
    run(1);
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    s_en  = 1'b0;
    run(3);
    s_en = 1'b1;
    run(20);

    // Randomized traffic, including zero and large increments and stray resets.
    for (int i = 0; i < 3000; i++) begin
      s_en  = ($urandom_range(0, 3) != 0);
      s_rst = ($urandom_range(0, 499) == 0);
      if (!s_valid && $urandom_range(0, 39) == 0) begin
        s_valid = 1'b1;
        r = $urandom_range(0, 3);
        case (r)
          0:       s_incr = 16'h0000;
          1:       s_incr = 16'($urandom_range(1, 255));
          2:       s_incr = 16'($urandom_range(256, 4096));
          default: s_incr = 16'($urandom);
        endcase
        s_step = 8'($urandom);
      end
      tick();
      if (m_acc || s_rst) s_valid = 1'b0;
    end
    s_rst = 1'b0;
    s_valid = 1'b0;
    s_en = 1'b0;
    run(3);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
